// File: rtl/branch_resolve_ctrl.sv
// branch_resolve_ctrl: stalls fetch on a detected branch, then redirects and flushes or releases once EX resolves it
module branch_resolve_ctrl #(
  parameter int WIDTH_DATA_LENGTH = 32,
  parameter int MAX_WAIT = 4,
  parameter int CNT_WIDTH = 16
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         Br_Dectected,
  input  logic                         Resolve_Valid,
  input  logic                         Br_Taken,
  input  logic [WIDTH_DATA_LENGTH-1:0] Target_PC,
  output logic                         PC_Stall,
  output logic                         PC_Redirect,
  output logic [WIDTH_DATA_LENGTH-1:0] Redirect_PC,
  output logic                         Flush,
  output logic                         Timeout_Err,
  output logic [CNT_WIDTH-1:0]         Branch_Count,
  output logic [CNT_WIDTH-1:0]         Taken_Count
);
  localparam int WW = $clog2(MAX_WAIT);
  typedef enum logic [1:0] {IDLE, WAIT, REDIRECT} state_t;
  state_t                       state_q;
  logic [WW-1:0]                wcnt_q;
  logic [WIDTH_DATA_LENGTH-1:0] rpc_q;
  logic                         to_q;
  logic [CNT_WIDTH-1:0]         bc_q, tc_q;
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      wcnt_q  <= '0;
      rpc_q   <= '0;
      to_q    <= 1'b0;
      bc_q    <= '0;
      tc_q    <= '0;
    end else begin
      case (state_q)
        IDLE: if (Br_Dectected) begin
          state_q <= WAIT;
          wcnt_q  <= '0;
          bc_q    <= bc_q + CNT_WIDTH'(1);
        end
        WAIT: begin
          wcnt_q <= wcnt_q + WW'(1);
          if (Resolve_Valid) begin
            if (Br_Taken) begin
              rpc_q   <= Target_PC;
              state_q <= REDIRECT;
            end else state_q <= IDLE;
          end else if (wcnt_q == WW'(MAX_WAIT - 1)) begin
            to_q    <= 1'b1;
            state_q <= IDLE;
          end
        end
        default: begin
          tc_q    <= tc_q + CNT_WIDTH'(1);
          state_q <= IDLE;
        end
      endcase
    end
  end
  // stall is gated by rst so an asserted reset silences the IDLE-state Mealy term too
  assign PC_Stall     = !rst && (state_q == WAIT || (state_q == IDLE && Br_Dectected));
  assign PC_Redirect  = state_q == REDIRECT;
  assign Flush        = state_q == REDIRECT;
  assign Redirect_PC  = rpc_q;
  assign Timeout_Err  = to_q;
  assign Branch_Count = bc_q;
  assign Taken_Count  = tc_q;
endmodule

// File: tb/tb_branch_resolve_ctrl.sv
// tb_branch_resolve_ctrl: episode-level reference model driving directed and random branch scenarios
module tb_branch_resolve_ctrl;
  localparam int W = 32;
  localparam int MW = 4;
  localparam int CW = 4;
  logic clk = 1'b0, rst;
  logic br, rv, bt;
  logic [W-1:0] tpc;
  logic stall, redir, flush, to_err;
  logic [W-1:0] rpc;
  logic [CW-1:0] bcnt, tcnt;
  int n_tests = 0, n_fail = 0;
  logic [W-1:0] m_rpc;
  logic m_to;
  int m_bc, m_tc;
  bit br_hold = 0;
  branch_resolve_ctrl #(.WIDTH_DATA_LENGTH(W), .MAX_WAIT(MW), .CNT_WIDTH(CW)) dut (
    .clk(clk), .rst(rst), .Br_Dectected(br), .Resolve_Valid(rv), .Br_Taken(bt),
    .Target_PC(tpc), .PC_Stall(stall), .PC_Redirect(redir), .Redirect_PC(rpc),
    .Flush(flush), .Timeout_Err(to_err), .Branch_Count(bcnt), .Taken_Count(tcnt)
  );
  always #5 clk = ~clk;
  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask
  task automatic chk_state(input logic e_stall, input logic e_red);
    chk("stall", stall, e_stall);
    chk("redirect", redir, e_red);
    chk("flush", flush, e_red);
    chk("redirect_pc", rpc, m_rpc);
    chk("timeout", to_err, m_to);
    chk("branch_cnt", bcnt, m_bc % (1 << CW));
    chk("taken_cnt", tcnt, m_tc % (1 << CW));
  endtask
  task automatic step(input logic b, input logic v, input logic t, input logic [W-1:0] pc,
                      input logic e_stall, input logic e_red);
    br = b; rv = v; bt = t; tpc = pc;
    #3;
    chk_state(e_stall, e_red);
    @(posedge clk);
    #1;
  endtask
  task automatic do_reset(input logic b);
    br = b; rv = 1'b0; rst = 1'b1;
    #2;
    m_rpc = '0; m_to = 1'b0; m_bc = 0; m_tc = 0;
    chk_state(1'b0, 1'b0);
    @(posedge clk);
    #1;
    rst = 1'b0; br = 1'b0;
  endtask
  function automatic logic nb();
    return br_hold ? 1'b1 : logic'($urandom_range(0, 1));
  endfunction
  function automatic logic rb();
    return logic'($urandom_range(0, 1));
  endfunction
  // k = WAIT cycle on which EX resolves (1..MW); k = 0 means EX never answers
  task automatic episode(input int gap, input int k, input logic taken, input logic [W-1:0] pc);
    for (int i = 0; i < gap; i++) step(1'b0, rb(), rb(), $urandom, 1'b0, 1'b0);
    step(1'b1, rb(), rb(), $urandom, 1'b1, 1'b0);
    m_bc++;
    for (int i = 1; i <= MW; i++) begin
      if (i == k) begin
        step(nb(), 1'b1, taken, pc, 1'b1, 1'b0);
        if (taken) m_rpc = pc;
        break;
      end
      step(nb(), 1'b0, rb(), $urandom, 1'b1, 1'b0);
      if (k == 0 && i == MW) m_to = 1'b1;
    end
    if (taken && k != 0) begin
      step(nb(), rb(), rb(), $urandom, 1'b0, 1'b1);
      m_tc++;
    end
  endtask
  initial begin
    br = 0; rv = 0; bt = 0; tpc = '0;
    do_reset(1'b0);
    step(1'b1, 1'b0, 1'b0, '0, 1'b1, 1'b0);
    m_bc++;
    step(1'b1, 1'b0, 1'b0, '0, 1'b1, 1'b0);
    do_reset(1'b1);
    step(1'b0, 1'b0, 1'b0, '0, 1'b0, 1'b0);
    episode(1, 2, 1'b1, 32'h0000_0040);
    chk("taken_rpc", rpc, 32'h40);
    episode(1, 2, 1'b0, 32'h0000_1234);
    chk("nt_rpc", rpc, 32'h40);
    episode(0, 0, 1'b0, '0);
    step(1'b0, 1'b0, 1'b0, '0, 1'b0, 1'b0);
    chk("timeout_set", to_err, 1'b1);
    do_reset(1'b0);
    step(1'b0, 1'b0, 1'b0, '0, 1'b0, 1'b0);
    episode(0, MW, 1'b1, 32'hdead_beef);
    br_hold = 1;
    episode(0, 1, 1'b1, 32'h0000_0100);
    episode(0, 1, 1'b1, 32'h0000_0200);
    br_hold = 0;
    step(1'b0, 1'b0, 1'b0, '0, 1'b0, 1'b0);
    do_reset(1'b0);
    repeat (17) episode(0, 1, 1'b1, $urandom);
    step(1'b0, 1'b0, 1'b0, '0, 1'b0, 1'b0);
    chk("tc_wrap", tcnt, 4'd1);
    repeat (300) episode($urandom_range(0, 3), $urandom_range(0, MW), rb(), $urandom);
    step(1'b0, 1'b0, 1'b0, '0, 1'b0, 1'b0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
